md5_core: RTL and testbench
===========================

Name: md5_core

Overview:
- Fully pipelined MD5 compression engine for one pre-padded 512-bit block. Accepts one block per enabled clock and returns the final MD5 digest as four 32-bit words.
- Also returns the 152-bit message prefix (a 19-byte candidate string), delayed to stay aligned with its digest.
- Sits in the hash-search datapath between the candidate-message generator and the digest comparator.

Parameters:
- MSG_BITS, 152, width of m_out: top MSG_BITS of m_in carried through the pipeline.
- LATENCY, 65, fixed cycles from an accepted valid_in to its valid_out: 64 round stages plus 1 finalize stage. Not meant to be overridden.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  global clock enable; 0 freezes the whole pipeline.
- m_in  in  512  padded block; m_in[511:504] is message byte 0, m_in[7:0] is byte 63.
- valid_in  in  1  m_in is valid this cycle.
- a_out  out  32  digest bytes 0-3, byte 0 in [31:24].
- b_out  out  32  digest bytes 4-7.
- c_out  out  32  digest bytes 8-11.
- d_out  out  32  digest bytes 12-15.
- m_out  out  152  m_in[511:360] of the block producing this digest.
- valid_out  out  1  outputs are valid this cycle.

Behaviour:
- Reset: asynchronous, active-high; interface fixed. All stage valid bits clear. a_out, b_out, c_out, d_out, m_out and valid_out reset to 0. Data registers in the pipeline may also clear.
- Word extraction: MD5 word M[j] is little-endian from bytes 4j..4j+3, i.e. M[j] = {byte4j+3, byte4j+2, byte4j+1, byte4j}, where byte k = m_in[511-8k -: 8].
- Padding and length: the core does no padding. The caller supplies 0x80 terminator, zeros, and a 64-bit little-endian bit length in bytes 56-63.
- Initial state: A=67452301, B=efcdab89, C=98badcfe, D=10325476 (hex).
- Round stages: one stage per round i (0..63), registered. Each stage:
  - F = (B&C)|(~B&D) for i<16; (D&B)|(~D&C) for i<32; B^C^D for i<48; C^(B|~D) otherwise.
  - g = i; (5i+1) mod 16; (3i+5) mod 16; (7i) mod 16 for the same ranges.
  - newB = B + rotl(A + F + K[i] + M[g], s[i]), all mod 2^32.
  - newA = D, newD = C, newC = B.
  - K[i] = floor(abs(sin(i+1)) * 2^32).
  - s per round group: 7,12,17,22 / 5,9,14,20 / 4,11,16,23 / 6,10,15,21.
  - K and s are per-stage constants, not lookups.
- Finalize stage: add initial A..D to the round-63 results mod 2^32, then byte-swap each word onto a_out..d_out. Result: {a_out,b_out,c_out,d_out} equals the conventional hex digest.
- Stage contents: every stage carries valid and the full 512-bit block (later rounds need all words). m_out is m_in[511:360] from the finalize stage.
- Throughput and ordering: a new block may enter on every enabled cycle, including back-to-back. Outputs emerge in input order.
- Latency: exactly LATENCY enabled cycles. valid_in sampled high at enabled edge N gives valid_out high after enabled edge N+64, for one enabled cycle per block.
- Enable: en=0 holds every register, including outputs, and ignores valid_in. Latency counts enabled edges only.
- Idle inputs: valid_in=0 with any m_in inserts a bubble and valid_out is 0 in its slot. Data may still propagate, but valid_out must be 0 for it.
- Reset mid-operation: all in-flight blocks are discarded; no valid_out until new blocks traverse the full pipeline.

Test Plan:
1. Reset, then "The quick brown fox" (m_in = 54686520717569636b2062726f776e20666f78 ‖ 80 ‖ zeros ‖ length 98000000_00000000) -> valid_out one cycle, 65 cycles after input; digest a2004f37 730b9445 670a738f a0fc9ee5; m_out equals the 152-bit prefix.
2. Back-to-back inputs on consecutive cycles:
   - "The quick brown fox".
   - "Hello World 1234567" (48656c6c6f20576f726c642031323334353637).
   - "This is a test. 123" (546869732069732061207465737 42e20313233).
   - Expected: three consecutive valid_out cycles, in order, with a2004f37..., then ac98cf84 ae657376 cea165e6 729ddb39, then caea4868 5020e1b5 11a454f6 60943eaa.
3. Empty message (m_in = 80 followed by zeros, length 0) -> d41d8cd9 8f00b204 e9800998 ecf8427e.
4. Drop en for 10 cycles while blocks are in flight -> outputs frozen; digests still correct, delayed by exactly 10 cycles.
5. Assert reset while blocks are in flight -> valid_out and outputs go to 0 immediately, and no stale valid_out afterwards.
6. Idle after reset with valid_in=0 for more than 100 cycles -> valid_out stays 0.

Source files
------------

// File: rtl/md5_core.sv
// md5_core: fully pipelined MD5 compression of one pre-padded 512-bit block.
// There are 64 registered round stages and one finalize stage, so one block
// can enter on every enabled clock. The 152-bit message prefix travels with
// its digest.
module md5_core #(
  parameter int MSG_BITS = 152,
  parameter int LATENCY  = 65
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [511:0]        m_in,
  input  logic                valid_in,
  output logic [31:0]         a_out,
  output logic [31:0]         b_out,
  output logic [31:0]         c_out,
  output logic [31:0]         d_out,
  output logic [MSG_BITS-1:0] m_out,
  output logic                valid_out
);

  // One register stage per round; the remaining cycle is the finalize stage.
  localparam int STAGES = LATENCY - 1;

  localparam logic [31:0] INIT_A = 32'h67452301;
  localparam logic [31:0] INIT_B = 32'hefcdab89;
  localparam logic [31:0] INIT_C = 32'h98badcfe;
  localparam logic [31:0] INIT_D = 32'h10325476;

  // K[i] = floor(abs(sin(i+1)) * 2^32). Each stage picks its own entry at
  // elaboration, so every entry becomes a hard-wired constant.
  localparam logic [31:0] K_TAB [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amounts: four per round group, cycling with i mod 4.
  localparam int S_TAB [0:15] = '{
    7, 12, 17, 22,
    5,  9, 14, 20,
    4, 11, 16, 23,
    6, 10, 15, 21
  };

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int GRP  = gi / 16;
      localparam int G    = (GRP == 0) ? gi :
                            (GRP == 1) ? (5 * gi + 1) % 16 :
                            (GRP == 2) ? (3 * gi + 5) % 16 :
                                         (7 * gi) % 16;
      localparam int S    = S_TAB[GRP * 4 + gi % 4];
      // Bit position of byte 4G; the word is assembled little-endian from here.
      localparam int BASE = 511 - 32 * G;

      logic         v_prev;
      logic [31:0]  a_prev, b_prev, c_prev, d_prev;
      logic [511:0] blk_prev;

      logic [31:0]  f_val, m_word, sum_val, rot_val, b_next;

      logic         v_reg;
      logic [31:0]  a_reg, b_reg, c_reg, d_reg;
      logic [511:0] blk_reg;

      if (gi == 0) begin : g_src
        assign v_prev   = valid_in;
        assign a_prev   = INIT_A;
        assign b_prev   = INIT_B;
        assign c_prev   = INIT_C;
        assign d_prev   = INIT_D;
        assign blk_prev = m_in;
      end else begin : g_src
        assign v_prev   = g_stage[gi-1].v_reg;
        assign a_prev   = g_stage[gi-1].a_reg;
        assign b_prev   = g_stage[gi-1].b_reg;
        assign c_prev   = g_stage[gi-1].c_reg;
        assign d_prev   = g_stage[gi-1].d_reg;
        assign blk_prev = g_stage[gi-1].blk_reg;
      end

      if (GRP == 0) begin : g_f
        assign f_val = (b_prev & c_prev) | (~b_prev & d_prev);
      end else if (GRP == 1) begin : g_f
        assign f_val = (d_prev & b_prev) | (~d_prev & c_prev);
      end else if (GRP == 2) begin : g_f
        assign f_val = b_prev ^ c_prev ^ d_prev;
      end else begin : g_f
        assign f_val = c_prev ^ (b_prev | ~d_prev);
      end

      assign m_word  = {blk_prev[BASE-24 -: 8], blk_prev[BASE-16 -: 8],
                        blk_prev[BASE-8 -: 8],  blk_prev[BASE -: 8]};
      assign sum_val = a_prev + f_val + K_TAB[gi] + m_word;
      assign rot_val = {sum_val[31-S:0], sum_val[31:32-S]};
      assign b_next  = b_prev + rot_val;

      // Round register: new B from the mixer, A/C/D rotate through.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v_reg   <= 1'b0;
          a_reg   <= '0;
          b_reg   <= '0;
          c_reg   <= '0;
          d_reg   <= '0;
          blk_reg <= '0;
        end else if (en) begin
          v_reg   <= v_prev;
          a_reg   <= d_prev;
          b_reg   <= b_next;
          c_reg   <= b_prev;
          d_reg   <= c_prev;
          blk_reg <= blk_prev;
        end
      end
    end
  endgenerate

  logic         v_last;
  logic [31:0]  a_last, b_last, c_last, d_last;
  logic [511:0] blk_last;

  assign v_last   = g_stage[STAGES-1].v_reg;
  assign a_last   = g_stage[STAGES-1].a_reg;
  assign b_last   = g_stage[STAGES-1].b_reg;
  assign c_last   = g_stage[STAGES-1].c_reg;
  assign d_last   = g_stage[STAGES-1].d_reg;
  assign blk_last = g_stage[STAGES-1].blk_reg;

  // After the last round only the message prefix is still wanted.
  logic unused_blk;
  assign unused_blk = ^blk_last[511-MSG_BITS:0];

  // Finalize: add the chaining values, then byte-swap into digest order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      c_out     <= '0;
      d_out     <= '0;
      m_out     <= '0;
    end else if (en) begin
      valid_out <= v_last;
      a_out     <= bswap(a_last + INIT_A);
      b_out     <= bswap(b_last + INIT_B);
      c_out     <= bswap(c_last + INIT_C);
      d_out     <= bswap(d_last + INIT_D);
      m_out     <= blk_last[511 -: MSG_BITS];
    end
  end

endmodule

// File: tb/tb_md5_core.sv
// tb_md5_core: directed vectors for md5_core, checked against a loop-style
// MD5 reference with a scoreboard that tracks enabled-edge latency.
module tb_md5_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [511:0] m_in;
  logic         valid_in;
  logic [31:0]  a_out, b_out, c_out, d_out;
  logic [151:0] m_out;
  logic         valid_out;

  md5_core dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .m_in      (m_in),
    .valid_in  (valid_in),
    .a_out     (a_out),
    .b_out     (b_out),
    .c_out     (c_out),
    .d_out     (d_out),
    .m_out     (m_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  localparam bit [151:0] FOX   = 152'h54686520717569636b2062726f776e20666f78;
  localparam bit [151:0] HELLO = 152'h48656c6c6f20576f726c642031323334353637;
  localparam bit [151:0] TEST  = 152'h54686973206973206120746573742e20313233;
  localparam bit [127:0] D_FOX   = 128'ha2004f37_730b9445_670a738f_a0fc9ee5;
  localparam bit [127:0] D_HELLO = 128'hac98cf84_ae657376_cea165e6_729ddb39;
  localparam bit [127:0] D_TEST  = 128'hcaea4868_5020e1b5_11a454f6_60943eaa;
  localparam bit [127:0] D_EMPTY = 128'hd41d8cd9_8f00b204_e9800998_ecf8427e;

  int n_cmp = 0;
  int n_bad = 0;

  bit [31:0] ktab [64];
  int        s_tab [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20},
                              '{4, 11, 16, 23}, '{6, 10, 15, 21}};

  typedef struct {
    bit [127:0] dig;
    bit [151:0] pfx;
    int         due;
  } exp_t;

  exp_t q [$];
  int   edge_cnt = 0;
  bit   last_valid = 1'b0;
  exp_t last_exp;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic bit [31:0] bsw(input bit [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Straightforward MD5 of one already-padded block.
  function automatic bit [127:0] md5_ref(input bit [511:0] blk);
    bit [31:0] w [16];
    bit [31:0] a, b, c, d, f, t, x;
    int g, sh;
    for (int j = 0; j < 16; j++)
      w[j] = {blk[511-8*(4*j+3) -: 8], blk[511-8*(4*j+2) -: 8],
              blk[511-8*(4*j+1) -: 8], blk[511-8*(4*j) -: 8]};
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b & c) | (~b & d); g = i;                end
        1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      endcase
      x  = a + f + ktab[i] + w[g];
      sh = s_tab[i / 16][i % 4];
      t  = d;
      d  = c;
      c  = b;
      b  = b + ((x << sh) | (x >> (32 - sh)));
      a  = t;
    end
    a = a + 32'h67452301; b = b + 32'hefcdab89;
    c = c + 32'h98badcfe; d = d + 32'h10325476;
    return {bsw(a), bsw(b), bsw(c), bsw(d)};
  endfunction

  // 19-byte message, 0x80 terminator, zeros, bit length 152 little-endian.
  function automatic bit [511:0] build(input bit [151:0] p);
    return {p, 8'h80, 288'b0, 8'h98, 56'b0};
  endfunction

  // Scoreboard: samples inputs at each edge, checks outputs 1 time unit later.
  always @(posedge clk) begin
    bit         en_s, v_s, r_s, exp_v;
    bit [511:0] m_s;
    exp_t       e;
    en_s = en; v_s = valid_in; r_s = reset; m_s = m_in;
    #1;
    if (r_s) begin
      q.delete();
      last_valid = 1'b0;
      chk("rst_valid", valid_out, 0);
      chk("rst_digest", {a_out, b_out, c_out, d_out}, 0);
      chk("rst_msg", m_out, 0);
    end else if (en_s) begin
      edge_cnt++;
      if (v_s) begin
        e.dig = md5_ref(m_s);
        e.pfx = m_s[511:360];
        e.due = edge_cnt + 64;
        q.push_back(e);
      end
      while (q.size() > 0 && q[0].due < edge_cnt) e = q.pop_front();
      exp_v = (q.size() > 0) && (q[0].due == edge_cnt);
      chk("sb_valid", valid_out, exp_v);
      if (exp_v) begin
        e = q.pop_front();
        chk("sb_digest", {a_out, b_out, c_out, d_out}, e.dig);
        chk("sb_msg", m_out, e.pfx);
        last_exp = e;
      end
      last_valid = exp_v;
    end else begin
      chk("hold_valid", valid_out, last_valid);
      if (last_valid) begin
        chk("hold_digest", {a_out, b_out, c_out, d_out}, last_exp.dig);
        chk("hold_msg", m_out, last_exp.pfx);
      end
    end
  end

  task automatic wait_valid(input int budget, output int cycles);
    bit ok;
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget && !ok) begin
      @(posedge clk);
      #1;
      cycles++;
      if (valid_out) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_valid: no valid_out within %0d cycles", budget);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int i = 0; i < 64; i++) begin
      real r;
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      ktab[i] = 32'(longint'($floor(r * 4294967296.0)));
    end

    // Pin the reference itself to known constants.
    chk("model_k0", ktab[0], 32'hd76aa478);
    chk("model_k63", ktab[63], 32'heb86d391);
    chk("model_fox", md5_ref(build(FOX)), D_FOX);
    chk("model_hello", md5_ref(build(HELLO)), D_HELLO);
    chk("model_test", md5_ref(build(TEST)), D_TEST);
    chk("model_empty", md5_ref({8'h80, 504'b0}), D_EMPTY);

    reset = 1'b1; en = 1'b1; valid_in = 1'b0; m_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", valid_out, 0);
    chk("reset_a", a_out, 0);
    chk("reset_m", m_out, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single block, latency and single-cycle valid.
    m_in = build(FOX); valid_in = 1'b1;
    @(posedge clk); #1; valid_in = 1'b0;
    wait_valid(200, cnt);
    chk("t1_latency", cnt + 1, 65);
    chk("t1_digest", {a_out, b_out, c_out, d_out}, D_FOX);
    chk("t1_msg", m_out, FOX);
    @(posedge clk); #1;
    chk("t1_single", valid_out, 0);

    // 2: back-to-back blocks.
    @(negedge clk); m_in = build(FOX);   valid_in = 1'b1;
    @(negedge clk); m_in = build(HELLO);
    @(negedge clk); m_in = build(TEST);
    @(negedge clk); valid_in = 1'b0; m_in = '1;
    wait_valid(200, cnt);
    chk("t2_d1", {a_out, b_out, c_out, d_out}, D_FOX);
    @(posedge clk); #1;
    chk("t2_v2", valid_out, 1);
    chk("t2_d2", {a_out, b_out, c_out, d_out}, D_HELLO);
    chk("t2_m2", m_out, HELLO);
    @(posedge clk); #1;
    chk("t2_v3", valid_out, 1);
    chk("t2_d3", {a_out, b_out, c_out, d_out}, D_TEST);
    @(posedge clk); #1;
    chk("t2_end", valid_out, 0);

    // 3: empty message.
    @(negedge clk); m_in = {8'h80, 504'b0}; valid_in = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    wait_valid(200, cnt);
    chk("t3_digest", {a_out, b_out, c_out, d_out}, D_EMPTY);

    // 4: freeze for 10 cycles with outputs valid; valid_in is ignored meanwhile.
    @(negedge clk); m_in = build(FOX);   valid_in = 1'b1;
    @(negedge clk); m_in = build(HELLO);
    @(negedge clk); m_in = build(TEST);
    @(negedge clk); valid_in = 1'b0;
    wait_valid(200, cnt);
    chk("t4_d1", {a_out, b_out, c_out, d_out}, D_FOX);
    @(negedge clk); en = 1'b0; valid_in = 1'b1; m_in = build(152'h0123456789abcdef);
    repeat (10) begin
      @(posedge clk); #1;
      chk("t4_hold", {a_out, b_out, c_out, d_out}, D_FOX);
    end
    @(negedge clk); en = 1'b1; valid_in = 1'b0;
    wait_valid(5, cnt);
    chk("t4_resume", cnt, 1);
    chk("t4_d2", {a_out, b_out, c_out, d_out}, D_HELLO);
    @(posedge clk); #1;
    chk("t4_d3", {a_out, b_out, c_out, d_out}, D_TEST);

    // 5: reset while outputs are valid and more blocks are in flight.
    @(negedge clk); m_in = build(HELLO); valid_in = 1'b1;
    @(negedge clk); m_in = build(TEST);
    @(negedge clk); m_in = build(FOX);
    @(negedge clk); valid_in = 1'b0;
    wait_valid(200, cnt);
    #1; reset = 1'b1;
    #1;
    chk("t5_valid", valid_out, 0);
    chk("t5_digest", {a_out, b_out, c_out, d_out}, 0);
    chk("t5_msg", m_out, 0);
    @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // 6: long idle with random data and valid_in low.
    repeat (120) begin
      @(negedge clk); m_in = {16{$urandom()}};
    end
    chk("t6_idle", valid_out, 0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
